// File: rtl/muldiv_pkg.sv
// muldiv_pkg: RV32M opcode encodings and operand signedness helpers.
package muldiv_pkg;
    localparam logic [6:0] FNC7_MULDIV = 7'b0000001;
    localparam logic [2:0] FNC_MUL    = 3'd0;
    localparam logic [2:0] FNC_MULH   = 3'd1;
    localparam logic [2:0] FNC_MULHSU = 3'd2;
    localparam logic [2:0] FNC_MULHU  = 3'd3;
    localparam logic [2:0] FNC_DIV    = 3'd4;
    localparam logic [2:0] FNC_DIVU   = 3'd5;
    localparam logic [2:0] FNC_REM    = 3'd6;
    localparam logic [2:0] FNC_REMU   = 3'd7;

    function automatic logic rs1_signed(input logic [2:0] f);
        return f == FNC_MULH || f == FNC_MULHSU || f == FNC_DIV || f == FNC_REM;
    endfunction

    function automatic logic rs2_signed(input logic [2:0] f);
        return f == FNC_MULH || f == FNC_DIV || f == FNC_REM;
    endfunction
endpackage

// File: rtl/muldiv_sign_fix.sv
// muldiv_sign_fix: conditional two's-complement negation of two independent lanes.
module muldiv_sign_fix #(
    parameter int WA = 32,
    parameter int WB = 32
) (
    input  logic [WA-1:0] a,
    input  logic [WB-1:0] b,
    input  logic          neg_a,
    input  logic          neg_b,
    output logic [WA-1:0] fix_a,
    output logic [WB-1:0] fix_b
);
    always_comb begin
        fix_a = neg_a ? -a : a;
        fix_b = neg_b ? -b : b;
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide, one bit per cycle, valid/ready handshake.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam int CW = $clog2(XLEN);

    state_t            state;
    logic [CW-1:0]     count;
    logic [2:0]        op;
    logic              neg_a, neg_b;
    logic [XLEN-1:0]   opnd;
    logic [2*XLEN-1:0] acc, acc_next, fix_a;
    logic [XLEN-1:0]   mag_a, mag_b, fix_b, fin, spec_val;
    logic [XLEN:0]     sum, diff;
    logic              sa, sb, is_mul, div0, ovf;

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign is_mul    = !op[2];
    assign sa        = rs1_signed(funct3) & rs1_data[XLEN-1];
    assign sb        = rs2_signed(funct3) & rs2_data[XLEN-1];

    muldiv_sign_fix #(.WA(XLEN), .WB(XLEN)) u_pre (
        .a(rs1_data), .b(rs2_data), .neg_a(sa), .neg_b(sb), .fix_a(mag_a), .fix_b(mag_b)
    );

    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        sum      = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
        diff     = acc[2*XLEN-1:XLEN-1] - {1'b0, opnd};
        acc_next = is_mul ? {sum, acc[XLEN-1:1]}
                          : {diff[XLEN] ? acc[2*XLEN-2:XLEN-1] : diff[XLEN-1:0], acc[XLEN-2:0], !diff[XLEN]};
        div0     = funct3[2] && rs2_data == '0;
        ovf      = (funct3 == FNC_DIV || funct3 == FNC_REM) && rs1_data == {1'b1, {(XLEN-1){1'b0}}} && rs2_data == '1;
        spec_val = div0 ? (funct3[1] ? rs1_data : '1) : (funct3[1] ? '0 : rs1_data);
    end

    muldiv_sign_fix #(.WA(2*XLEN), .WB(XLEN)) u_post (
        .a(is_mul ? acc_next : {{XLEN{1'b0}}, acc_next[XLEN-1:0]}), .b(acc_next[2*XLEN-1:XLEN]),
        .neg_a(neg_a ^ neg_b), .neg_b(neg_a), .fix_a(fix_a), .fix_b(fix_b)
    );

    assign fin = op == FNC_MUL ? fix_a[XLEN-1:0] : is_mul ? fix_a[2*XLEN-1:XLEN] : op[1] ? fix_b : fix_a[XLEN-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op     <= '0;
            neg_a  <= 1'b0;
            neg_b  <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            result <= '0;
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    op     <= funct3;
                    neg_a  <= sa;
                    neg_b  <= sb;
                    opnd   <= funct3[2] ? mag_b : mag_a;
                    acc    <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                    count  <= '0;
                    result <= (div0 || ovf) ? spec_val : result;
                    state  <= (div0 || ovf) ? DONE : BUSY;
                end
                BUSY: begin
                    acc   <= acc_next;
                    count <= count + 1'b1;
                    if (count == CW'(XLEN-1)) begin
                        result <= fin;
                        state  <= DONE;
                    end
                end
                DONE: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: scoreboard bench for muldiv_unit with directed hand-computed vectors.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
    logic [2:0]  funct3 = '0;
    logic [31:0] rs1_data = '0, rs2_data = '0, result;
    logic        in_ready, out_valid;

    muldiv_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {logic [31:0] res; int lat;} exp_t;
    typedef struct {logic [2:0] f; logic [31:0] a; logic [31:0] b; logic [31:0] e; int lat;} vec_t;

    exp_t sb[$];
    int   checks = 0, failures = 0, cyc = 0, acc_cyc = 0;
    bit   seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    // Monitor: latency on first valid cycle, result on handshake
    always @(negedge clk) if (!rst) begin
        if (out_valid && !seen) begin
            seen = 1;
            if (sb.size() == 0) fail_now($sformatf("unexpected_valid result=%h", result));
            else check("latency", 32'(cyc + 1 - acc_cyc), 32'(sb[0].lat));
        end
        if (out_valid && out_ready) begin
            seen = 0;
            if (sb.size() > 0) check("result", result, sb.pop_front().res);
        end
    end

    task automatic accept(input logic [31:0] e, input int lat, input bit push);
        int n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail_now("accept_timeout");
        acc_cyc = cyc + 1;
        if (push) sb.push_back('{e, lat});
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] e, input int lat, input bit push);
        @(negedge clk);
        funct3 = f; rs1_data = a; rs2_data = b; in_valid = 1;
        accept(e, lat, push);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() > 0) begin
            fail_now("result_timeout");
            sb.delete();
        end
    endtask

    vec_t vecs[14] = '{
        '{FNC_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
        '{FNC_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
        '{FNC_DIVU,   32'h00000064, 32'h00000000, 32'hFFFFFFFF, 1},
        '{FNC_REMU,   32'h00000064, 32'h00000000, 32'h00000064, 1},
        '{FNC_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
        '{FNC_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
        '{FNC_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 33},
        '{FNC_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
        '{FNC_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 33},
        '{FNC_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33},
        '{FNC_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 33},
        '{FNC_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 33},
        '{FNC_MULH,   32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 33},
        '{FNC_DIVU,   32'hFFFFFFFF, 32'h00000003, 32'h55555555, 33}
    };

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit bad = 0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_in_ready", {31'b0, in_ready}, 32'h1);
        check("reset_out_valid", {31'b0, out_valid}, 32'h0);
        check("reset_result", result, 32'h0);
        @(negedge clk) rst = 0;

        foreach (vecs[i]) issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].e, vecs[i].lat, 1);
        wait_done();

        // Backpressure with the next request held on in_valid the whole time
        out_ready = 0;
        issue(FNC_DIVU, 32'h64, 32'h0, 32'hFFFFFFFF, 1, 1);
        funct3 = FNC_REMU; rs1_data = 32'h64; rs2_data = 32'h7; in_valid = 1;
        repeat (5) begin
            @(negedge clk);
            check("bp_out_valid", {31'b0, out_valid}, 32'h1);
            check("bp_in_ready", {31'b0, in_ready}, 32'h0);
            check("bp_result_hold", result, 32'hFFFFFFFF);
        end
        @(posedge clk);
        #1 out_ready = 1;
        @(negedge clk);
        check("bp_in_ready_still_low", {31'b0, in_ready}, 32'h0);
        @(negedge clk);
        check("bp_in_ready_after", {31'b0, in_ready}, 32'h1);
        check("bp_out_valid_after", {31'b0, out_valid}, 32'h0);
        accept(32'h2, 33, 1);
        wait_done();

        // Flush mid-divide
        issue(FNC_DIVU, 32'h64, 32'h3, 32'h0, 0, 0);
        repeat (9) @(posedge clk);
        #1 flush = 1;
        @(posedge clk);
        #1 flush = 0;
        check("flush_in_ready", {31'b0, in_ready}, 32'h1);
        check("flush_out_valid", {31'b0, out_valid}, 32'h0);
        repeat (40) begin
            @(negedge clk);
            if (out_valid) bad = 1;
        end
        check("flush_no_valid", {31'b0, bad}, 32'h0);
        issue(FNC_DIVU, 32'h64, 32'h7, 32'hE, 33, 1);
        wait_done();

        // Asynchronous reset mid-busy, asserted between edges
        issue(FNC_MUL, 32'h7, 32'h9, 32'h0, 0, 0);
        repeat (5) @(posedge clk);
        #3 rst = 1;
        #1;
        check("arst_out_valid", {31'b0, out_valid}, 32'h0);
        check("arst_result", result, 32'h0);
        check("arst_in_ready", {31'b0, in_ready}, 32'h1);
        #2 rst = 0;
        issue(FNC_MUL, 32'h3, 32'h5, 32'hF, 33, 1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
